rejestr_wejsc_filtr: RTL and testbench
======================================

# rejestr_wejsc_filtr

Parametrised PLC input image register with per-bit synchronisation, digital debounce filtering and scan-edge detection. Sits between the physical input pins and the CPU data path: raw inputs are filtered continuously, and on each scan strobe `ce` the filtered state is frozen into the process input image together with rising and falling edge flags for P/N contact instructions. Generalises the fixed 8×8-bit input register to N bytes, with filtering, edge flags and a valid flag.

## Interface
- `N_BYTES`, 8: number of 8-bit input bytes; total width W = 8*N_BYTES.
- `FILTER_LEN`, 4: consecutive clk cycles a changed input must hold before it is accepted, ≥1. Counter width is $clog2(FILTER_LEN+1).

- `clk`  in  1  system clock; all state updates on the falling edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  scan snapshot strobe; sampled on the falling edge of clk.
- `filt_en`  in  1  1 = debounce active, 0 = bypass, so the filter follows the synchroniser every cycle.
- `in_bus`  in  W  raw asynchronous inputs; byte k is bits [8k+7:8k].
- `out_bus`  out  W  input image, held between strobes.
- `rise_bus`  out  W  per-bit 0→1 flag from the last snapshot.
- `fall_bus`  out  W  per-bit 1→0 flag from the last snapshot.
- `image_valid`  out  1  set by the first `ce` after reset.
- `changed`  out  1  OR of rise_bus|fall_bus.

## Operation
- **Synchroniser:** two flops per bit, sync1 ← in_bus, then sync2 ← sync1, every edge. No reset dependence beyond clearing to 0.
- **Debounce**, per bit, with filter state `filt` and counter `cnt`, evaluated on pre-edge values:
  - filt_en=0: filt ← sync2, cnt ← 0.
  - sync2 == filt: cnt ← 0.
  - sync2 != filt and cnt == FILTER_LEN-1: filt ← sync2, cnt ← 0.
  - Otherwise cnt ← cnt+1.
  - A pulse or glitch shorter than FILTER_LEN cycles after synchronisation never reaches filt.
  - An alternating input keeps resetting cnt and is rejected.
- **Snapshot**, on an edge with ce=1:
  - out_bus ← filt.
  - rise_bus ← filt & ~out_bus and fall_bus ← ~filt & out_bus, using the old out_bus.
  - image_valid ← 1.
  - If image_valid was 0, the first snapshot forces rise_bus and fall_bus to 0. Inputs that are 1 out of reset report no false edges.
- **With ce=0:** out_bus, rise_bus, fall_bus and image_valid hold. Edge flags stay valid for a whole scan until the next strobe.
- **ce held high continuously:** snapshots every cycle, so an edge flag lasts exactly one cycle.
- **Simultaneous filt update and ce on the same edge:** the snapshot takes the pre-edge filt. The new value appears at the next strobe.
- **filt_en toggled 1→0 mid-count:** the counter clears and filt takes sync2 on that edge.
- **filt_en toggled 0→1:** filtering resumes from the current filt.
- **changed:** combinational OR of rise_bus|fall_bus.

## Timing
- Reset: sync1, sync2, filt, cnt, out_bus, rise_bus, fall_bus and image_valid are all 0 asynchronously. changed = 0.
- Reset asserted mid-operation clears everything immediately. After release, the next snapshot is a "first" one with no edge flags.
- Latency, with input stable from before edge 0:
  - sync2 is valid after edge 1.
  - filt updates at edge FILTER_LEN+1.
  - The earliest strobe capturing the change is at edge FILTER_LEN+2. For FILTER_LEN=4 that is edge 6.
- With filt_en=0: filt updates at edge 2 and the earliest capture is at edge 3.
- Outputs change only on falling edges of clk, or on rst_n assertion.

## Test plan
- **Reset:** assert rst_n=0 with in_bus all ones → all outputs 0. Release, hold in_bus, pulse ce once after ≥6 cycles → out_bus all ones, rise_bus = 0, image_valid = 1.
- **Debounce reject:** N_BYTES=8, FILTER_LEN=4, bit 3 high for 3 cycles then low, ce every cycle → out_bus bit 3 never 1, rise_bus = 0.
- **Debounce accept and edges:** bit 3 stays high with ce pulsed every 10 cycles.
  - out_bus[3] = 1 and rise_bus[3] = 1 after the first strobe at edge ≥6.
  - The next strobe clears rise_bus[3] with out_bus[3] still 1.
  - Dropping the input gives fall_bus[3] = 1 one strobe later.
- **Bypass:** filt_en=0, 1-cycle pulse on bit 63, ce high continuously → out_bus[63] = 1 for exactly one cycle, 3 edges after the pulse, with matching rise then fall flags.
- **Boundary:** ce on the same edge as a filt update → old value captured and the new value appears at the next strobe. Assert rst_n mid-count → the counter is lost and the bit needs a full FILTER_LEN again after release.

Source files
------------

// File: rtl/rejestr_wejsc_filtr.sv
// PLC input image register: two-flop synchroniser, per-bit debounce filter,
// and a scan snapshot with rising/falling edge flags. All state moves on the falling clock edge.
module rejestr_wejsc_filtr #(
  parameter int N_BYTES    = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   filt_en,
  input  logic [8*N_BYTES-1:0]   in_bus,
  output logic [8*N_BYTES-1:0]   out_bus,
  output logic [8*N_BYTES-1:0]   rise_bus,
  output logic [8*N_BYTES-1:0]   fall_bus,
  output logic                   image_valid,
  output logic                   changed
);

  localparam int W  = 8 * N_BYTES;
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  filt;
  logic [CW-1:0] cnt [W];

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_bus;
      sync2 <= sync1;
    end
  end

  // A bit is accepted only after sync2 has disagreed with filt for FILTER_LEN consecutive edges.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!filt_en) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // The first snapshot after reset has no previous image to compare against, so no edges.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bus     <= '0;
      rise_bus    <= '0;
      fall_bus    <= '0;
      image_valid <= 1'b0;
    end else if (ce) begin
      out_bus     <= filt;
      rise_bus    <= image_valid ? (filt & ~out_bus) : '0;
      fall_bus    <= image_valid ? (~filt & out_bus) : '0;
      image_valid <= 1'b1;
    end
  end

  assign changed = |(rise_bus | fall_bus);

endmodule

// File: tb/tb_rejestr_wejsc_filtr.sv
// Testbench for rejestr_wejsc_filtr: a behavioural scan model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rejestr_wejsc_filtr;

  localparam int N_BYTES    = 8;
  localparam int FILTER_LEN = 4;
  localparam int W          = 8 * N_BYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce;
  logic         filt_en;
  logic [W-1:0] in_bus;
  logic [W-1:0] out_bus;
  logic [W-1:0] rise_bus;
  logic [W-1:0] fall_bus;
  logic         image_valid;
  logic         changed;

  int checks = 0;
  int errors = 0;

  rejestr_wejsc_filtr #(.N_BYTES(N_BYTES), .FILTER_LEN(FILTER_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .filt_en     (filt_en),
    .in_bus      (in_bus),
    .out_bus     (out_bus),
    .rise_bus    (rise_bus),
    .fall_bus    (fall_bus),
    .image_valid (image_valid),
    .changed     (changed)
  );

  always #5 clk = ~clk;

  // Model: two-sample input delay, then a bit is accepted once it has disagreed
  // with the accepted value for FILTER_LEN consecutive samples; a scan freezes the accepted value.
  logic [W-1:0] m_s1, m_s2, m_filt, m_out, m_rise, m_fall;
  logic         m_valid;
  int           m_run [W];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0;
      m_out = '0; m_rise = '0; m_fall = '0; m_valid = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      if (ce) begin
        m_rise  = m_valid ? (m_filt & ~m_out) : '0;
        m_fall  = m_valid ? (~m_filt & m_out) : '0;
        m_out   = m_filt;
        m_valid = 1'b1;
      end
      for (int i = 0; i < W; i++) begin
        if (!filt_en) begin
          m_filt[i] = m_s2[i];
          m_run[i]  = 0;
        end else if (m_s2[i] != m_filt[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= FILTER_LEN) begin
            m_filt[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = in_bus;
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] in_v, input logic ce_v, input logic fe_v);
    in_bus  = in_v;
    ce      = ce_v;
    filt_en = fe_v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Every cycle, sample well away from the falling edge and compare against the model.
  always begin
    @(posedge clk);
    #1;
    checkOutput("cyc_out", out_bus, m_out);
    checkOutput("cyc_rise", rise_bus, m_rise);
    checkOutput("cyc_fall", fall_bus, m_fall);
    checkOutput("cyc_valid", W'(image_valid), W'(m_valid));
    checkOutput("cyc_changed", W'(changed), W'(|(m_rise | m_fall)));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus('1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;

    // Reset with all inputs high, then a first snapshot with no edges.
    tick(2);
    checkOutput("rst_out", out_bus, '0);
    checkOutput("rst_rise", rise_bus, '0);
    checkOutput("rst_fall", fall_bus, '0);
    checkOutput("rst_valid", W'(image_valid), '0);
    checkOutput("rst_changed", W'(changed), '0);
    rst_n = 1'b1;
    tick(8);
    applyStimulus('1, 1'b1, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b1);
    checkOutput("first_out", out_bus, '1);
    checkOutput("first_rise", rise_bus, '0);
    checkOutput("first_fall", fall_bus, '0);
    checkOutput("first_valid", W'(image_valid), W'(1));
    checkOutput("model_first_out", m_out, '1);

    // Debounce reject: a three-cycle pulse on bit 3 never reaches the image.
    applyStimulus('0, 1'b1, 1'b1);
    tick(8);
    checkOutput("rej_pre_out", out_bus, '0);
    checkOutput("rej_pre_fall", fall_bus, '0);
    applyStimulus(64'h8, 1'b1, 1'b1);
    tick(3);
    applyStimulus('0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      checkOutput("rej_out3", W'(out_bus[3]), '0);
      checkOutput("rej_rise3", W'(rise_bus[3]), '0);
    end

    // Debounce accept with strobes every ten cycles.
    applyStimulus(64'h8, 1'b0, 1'b1);
    tick(9);
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    checkOutput("acc_out", out_bus, 64'h8);
    checkOutput("acc_rise", rise_bus, 64'h8);
    checkOutput("acc_changed", W'(changed), W'(1));
    checkOutput("model_acc_rise", m_rise, 64'h8);
    tick(5);
    checkOutput("acc_hold_rise", rise_bus, 64'h8);
    tick(3);
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    checkOutput("acc2_out", out_bus, 64'h8);
    checkOutput("acc2_rise", rise_bus, '0);
    applyStimulus('0, 1'b0, 1'b1);
    tick(9);
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    checkOutput("acc3_out", out_bus, '0);
    checkOutput("acc3_fall", fall_bus, 64'h8);

    // Bypass: a one-cycle pulse on bit 63 shows up in the image for exactly one cycle.
    applyStimulus('0, 1'b1, 1'b0);
    tick(6);
    applyStimulus(64'h8000_0000_0000_0000, 1'b1, 1'b0);
    tick(1);
    applyStimulus('0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checkOutput("byp_out63", W'(out_bus[63]), W'(k == 3));
      checkOutput("byp_rise63", W'(rise_bus[63]), W'(k == 3));
      checkOutput("byp_fall63", W'(fall_bus[63]), W'(k == 4));
      tick(1);
    end

    // Strobe on the same edge as the filter update captures the old value.
    applyStimulus('0, 1'b1, 1'b1);
    tick(6);
    applyStimulus(64'h1, 1'b0, 1'b1);
    tick(5);
    ce = 1'b1;
    tick(1);
    checkOutput("same_edge_out0", W'(out_bus[0]), '0);
    checkOutput("same_edge_rise0", W'(rise_bus[0]), '0);
    tick(1);
    ce = 1'b0;
    checkOutput("next_strobe_out0", W'(out_bus[0]), W'(1));
    checkOutput("next_strobe_rise0", W'(rise_bus[0]), W'(1));

    // Reset mid-count: the bit needs a full filter period again after release.
    applyStimulus('0, 1'b1, 1'b1);
    tick(6);
    applyStimulus(64'h2, 1'b0, 1'b1);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    checkOutput("midrst_out", out_bus, '0);
    checkOutput("midrst_valid", W'(image_valid), '0);
    checkOutput("midrst_changed", W'(changed), '0);
    rst_n = 1'b1;
    tick(5);
    ce = 1'b1;
    tick(1);
    checkOutput("postrst_out1", W'(out_bus[1]), '0);
    checkOutput("postrst_valid", W'(image_valid), W'(1));
    checkOutput("postrst_rise", rise_bus, '0);
    tick(1);
    ce = 1'b0;
    checkOutput("postrst2_out", out_bus, 64'h2);
    checkOutput("postrst2_rise", rise_bus, 64'h2);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
